// File: rtl/bus_arbiter.sv
// Purpose : two-master round-robin arbiter in front of a single 16-bit data bus.
// Latency : one cycle to arbitrate, then the access completes in the first cycle S_Waitreq is low.
// Backpr. : the granted master sees S_Waitreq; the other master is held with Waitreq = 1.
//
// Ports:
//   Clock, Resetn                          clock, asynchronous active-low reset
//   M0_*/M1_* (Read, Write, Addr, WData)   master request strobes, address, write data
//   M0_/M1_ Waitreq, Err                   per-master stall and timeout-abort pulse
//   M_RData                                slave read data broadcast to both masters
//   S_Read, S_Write, S_Addr, S_WData       strobes, address and data towards the data bus
//   S_RData, S_Waitreq                     data bus read data and stall
//
// Build option: define ARB_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES stalled cycles.
// Without it, no counter is built, M0_Err/M1_Err stay 0 and a grant waits indefinitely.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        M0_Read,
    input  logic        M0_Write,
    input  logic [15:0] M0_Addr,
    input  logic [15:0] M0_WData,
    output logic        M0_Waitreq,
    output logic        M0_Err,
    input  logic        M1_Read,
    input  logic        M1_Write,
    input  logic [15:0] M1_Addr,
    input  logic [15:0] M1_WData,
    output logic        M1_Waitreq,
    output logic        M1_Err,
    output logic [15:0] M_RData,
    output logic        S_Read,
    output logic        S_Write,
    output logic [15:0] S_Addr,
    output logic [15:0] S_WData,
    input  logic [15:0] S_RData,
    input  logic        S_Waitreq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;

    logic        req0, req1;
    logic        gnt_is1;
    logic        sel_rd, sel_wr, sel_req, oth_req;
    logic [15:0] sel_addr, sel_wdat;
    logic        grant_wait, grant_err;
    logic        timeout_hit;

    assign req0    = M0_Read | M0_Write;
    assign req1    = M1_Read | M1_Write;
    assign M_RData = S_RData;

    // Signals of whichever master currently owns the bus.
    assign gnt_is1  = (state_q == GNT1);
    assign sel_rd   = gnt_is1 ? M1_Read  : M0_Read;
    assign sel_wr   = gnt_is1 ? M1_Write : M0_Write;
    assign sel_req  = gnt_is1 ? req1     : req0;
    assign oth_req  = gnt_is1 ? req0     : req1;
    assign sel_addr = gnt_is1 ? M1_Addr  : M0_Addr;
    assign sel_wdat = gnt_is1 ? M1_WData : M0_WData;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The counter restarts whenever the state moves; while a grant holds,
    // every cycle is necessarily a stalled one (completion or drop leaves GNTn).
    always_comb begin
        cnt_d = '0;
        if ((state_q != IDLE) && (state_d == state_q)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (state_q != IDLE) && S_Waitreq &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;

    // Parameter only shapes the timeout counter; keep it referenced here.
    if (TIMEOUT_CYCLES < 1) begin : g_no_timeout_param
    end
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        S_Read     = 1'b0;
        S_Write    = 1'b0;
        S_Addr     = 16'h0000;
        S_WData    = 16'h0000;
        M0_Waitreq = 1'b1;
        M1_Waitreq = 1'b1;
        M0_Err     = 1'b0;
        M1_Err     = 1'b0;
        grant_wait = 1'b1;
        grant_err  = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the master that did not finish last wins.
                if (req0 && req1) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end

            GNT0, GNT1: begin
                S_Addr     = sel_addr;
                S_WData    = sel_wdat;
                S_Write    = sel_wr;
                S_Read     = sel_rd & ~sel_wr;   // a write wins over a simultaneous read
                grant_wait = S_Waitreq;

                if (!sel_req) begin
                    state_d = IDLE;
                end else if (!S_Waitreq || timeout_hit) begin
                    if (timeout_hit) begin
                        // Abort: release the master with an error, no bus strobe.
                        grant_wait = 1'b0;
                        grant_err  = 1'b1;
                        S_Read     = 1'b0;
                        S_Write    = 1'b0;
                    end
                    last_gnt_d = gnt_is1;
                    if (oth_req) begin
                        state_d = gnt_is1 ? GNT0 : GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end

                if (gnt_is1) begin
                    M1_Waitreq = grant_wait;
                    M1_Err     = grant_err;
                end else begin
                    M0_Waitreq = grant_wait;
                    M0_Err     = grant_err;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule
